// File: rtl/bus_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_sched_pkg
// Description : Shared state encoding and width helper for the bus scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Never returns less than 1 so degenerate counters still have a bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker, scanning upward from last+1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import bus_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [W-1:0]     last,
    output logic [W-1:0]     winner,
    output logic             any_req
);

    int   w_idx;
    logic w_found;

    always_comb begin
        winner  = last;
        any_req = |req;
        w_found = 1'b0;
        w_idx   = 0;
        // The last owner is visited at i == N_REQ, giving it lowest priority.
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = (int'(last) + i) % N_REQ;
            if (!w_found && req[w_idx[W-1:0]]) begin
                winner  = w_idx[W-1:0];
                w_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_sched.sv
`default_nettype none
// ============================================================================
// Module      : bus_sched
// Description : Round-robin bus owner scheduler with active-low driver enables
//               and a turnaround gap between owners.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_sched
    import bus_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        oe_n,
    output logic [clog2(N_REQ)-1:0] owner,
    output logic                    busy,
    output logic                    timeout
);

    localparam int W           = clog2(N_REQ);
    localparam int HW          = clog2(MAX_HOLD + 1);
    localparam int TW          = clog2(TURN_CYC + 1);
    localparam int c_HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    state_t           r_state,   w_state_nxt;
    logic [N_REQ-1:0] r_gnt,     w_gnt_nxt;
    logic [N_REQ-1:0] r_oe_n,    w_oe_n_nxt;
    logic [W-1:0]     r_owner,   w_owner_nxt;
    logic [HW-1:0]    r_hold,    w_hold_nxt;
    logic [TW-1:0]    r_turn,    w_turn_nxt;
    logic             r_timeout, w_timeout_nxt;

    logic [W-1:0]     w_winner;
    logic             w_any;
    logic             w_own_done;
    logic             w_own_req;
    logic             w_expire;

    rr_pick #(
        .N_REQ (N_REQ),
        .W     (W)
    ) u_pick (
        .req     (req),
        .last    (r_owner),
        .winner  (w_winner),
        .any_req (w_any)
    );

    assign w_own_done = done[r_owner];
    assign w_own_req  = req[r_owner];
    assign w_expire   = (MAX_HOLD != 0) && (r_hold == HW'(c_HOLD_LAST));

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_oe_n_nxt    = r_oe_n;
        w_owner_nxt   = r_owner;
        w_hold_nxt    = r_hold;
        w_turn_nxt    = r_turn;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = DRIVE;
                    w_gnt_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
                    w_oe_n_nxt  = ~({{(N_REQ-1){1'b0}}, 1'b1} << w_winner);
                    w_owner_nxt = w_winner;
                    w_hold_nxt  = '0;
                end
            end
            DRIVE: begin
                w_hold_nxt = r_hold + 1'b1;
                if (w_own_done || !w_own_req || w_expire) begin
                    w_state_nxt   = TURN;
                    w_gnt_nxt     = '0;
                    w_oe_n_nxt    = '1;
                    w_turn_nxt    = '0;
                    // Flag only releases forced purely by the hold limit.
                    w_timeout_nxt = w_expire && !w_own_done && w_own_req;
                end
            end
            TURN: begin
                w_gnt_nxt  = '0;
                w_oe_n_nxt = '1;
                if (r_turn == TW'(TURN_CYC - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_turn_nxt = r_turn + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_oe_n_nxt  = '1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_oe_n    <= '1;
            r_owner   <= W'(N_REQ - 1);
            r_hold    <= '0;
            r_turn    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_oe_n    <= w_oe_n_nxt;
            r_owner   <= w_owner_nxt;
            r_hold    <= w_hold_nxt;
            r_turn    <= w_turn_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign oe_n    = r_oe_n;
    assign owner   = r_owner;
    assign busy    = (r_state != IDLE);
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bus_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_sched
// Description : Self-checking bench for bus_sched with a grant scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_sched;

    logic       clk;
    logic       rst;
    logic [3:0] req,  done;
    logic [3:0] gnt,  oe_n;
    logic [1:0] owner;
    logic       busy, timeout;
    logic [3:0] req3, done3;
    logic [3:0] gnt3, oe_n3;
    logic [1:0] owner3;
    logic       busy3, timeout3;

    int         n_checks;
    int         n_errors;
    logic [1:0] sb[$];

    bus_sched #(.N_REQ(4), .TURN_CYC(1), .MAX_HOLD(0)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .gnt(gnt), .oe_n(oe_n),
        .owner(owner), .busy(busy), .timeout(timeout)
    );

    bus_sched #(.N_REQ(4), .TURN_CYC(1), .MAX_HOLD(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .done(done3), .gnt(gnt3), .oe_n(oe_n3),
        .owner(owner3), .busy(busy3), .timeout(timeout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        n_checks++;
        if (!$onehot0(~oe_n)) begin
            n_errors++;
            $display("FAIL inv_onehot: oe_n=%b, required at most one low bit", oe_n);
        end
        n_checks++;
        if (oe_n !== ~gnt) begin
            n_errors++;
            $display("FAIL inv_oe_gnt: oe_n=%b gnt=%b, required oe_n == ~gnt", oe_n, gnt);
        end
        n_checks++;
        if (oe_n3 !== ~gnt3 || !$onehot0(~oe_n3)) begin
            n_errors++;
            $display("FAIL inv_dut3: oe_n=%b gnt=%b, required one-hot and complementary", oe_n3, gnt3);
        end
        n_checks++;
        if (timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL no_timeout: timeout=%b with hold limit disabled, required 0", timeout);
        end
    endtask

    task automatic wait_grant(input int exp_lat, input string tag);
        int         n;
        logic [1:0] exp_own;
        logic [3:0] exp_g;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 4'b0 && n < 20);
        n_checks++;
        if (gnt == 4'b0) begin
            n_errors++;
            $display("FAIL %s grant_wait: no grant after %0d cycles, required one", tag, n);
            return;
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL %s scoreboard: grant %b seen, required none", tag, gnt);
            return;
        end
        exp_own = sb.pop_front();
        exp_g   = 4'b0001 << exp_own;
        n_checks++;
        if (owner !== exp_own || gnt !== exp_g || oe_n !== ~exp_g) begin
            n_errors++;
            $display("FAIL %s grant: owner=%0d gnt=%b oe_n=%b, required owner=%0d gnt=%b oe_n=%b",
                     tag, owner, gnt, oe_n, exp_own, exp_g, ~exp_g);
        end
        n_checks++;
        if (n != exp_lat) begin
            n_errors++;
            $display("FAIL %s latency: %0d cycles, required %0d", tag, n, exp_lat);
        end
    endtask

    task automatic idle_out();
        req   = 4'b0;
        done  = 4'b0;
        req3  = 4'b0;
        done3 = 4'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0; done = 4'b0; req3 = 4'b0; done3 = 4'b0;
        repeat (2) tick();
        n_checks++;
        if (gnt !== 4'b0 || oe_n !== 4'hF || owner !== 2'd3 || busy !== 1'b0 || timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: gnt=%b oe_n=%b owner=%0d busy=%b timeout=%b, required 0000 1111 3 0 0",
                     gnt, oe_n, owner, busy, timeout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req = 4'b0001;
        sb.push_back(2'd0);
        wait_grant(1, "single");
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL single_busy: busy=%b, required 1", busy);
        end
        done = 4'b0001;
        tick();
        done = 4'b0;
        req  = 4'b0;
        n_checks++;
        if (gnt !== 4'b0 || oe_n !== 4'hF || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL single_turn: gnt=%b oe_n=%b busy=%b, required 0000 1111 1", gnt, oe_n, busy);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || oe_n !== 4'hF) begin
            n_errors++;
            $display("FAIL single_idle: busy=%b oe_n=%b, required 0 1111", busy, oe_n);
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        sb.push_back(2'd0); sb.push_back(2'd1); sb.push_back(2'd2);
        sb.push_back(2'd3); sb.push_back(2'd0);
        wait_grant(1, "rr_first");
        for (int k = 0; k < 4; k++) begin
            done = gnt;
            tick();
            done = 4'b0;
            wait_grant(2, "rr_next");
        end
        idle_out();
    endtask

    task automatic test_timeout();
        int n;
        req3 = 4'b0100;
        tick();
        n = 0;
        while (gnt3 != 4'b0 && n < 10) begin
            n++;
            tick();
        end
        n_checks++;
        if (n != 3) begin
            n_errors++;
            $display("FAIL hold_len: drove %0d cycles, required 3", n);
        end
        n_checks++;
        if (timeout3 !== 1'b1 || gnt3 !== 4'b0) begin
            n_errors++;
            $display("FAIL hold_release: timeout=%b gnt=%b, required 1 0000", timeout3, gnt3);
        end
        tick();
        n_checks++;
        if (timeout3 !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_pulse: timeout=%b on second gap cycle, required 0", timeout3);
        end
        tick();
        n_checks++;
        if (gnt3 !== 4'b0100 || owner3 !== 2'd2) begin
            n_errors++;
            $display("FAIL hold_regrant: gnt=%b owner=%0d, required 0100 2", gnt3, owner3);
        end
        idle_out();
    endtask

    task automatic test_wrap();
        req = 4'b1000;
        sb.push_back(2'd3);
        wait_grant(1, "wrap_setup");
        req  = 4'b1001;
        done = 4'b1000;
        sb.push_back(2'd0);
        tick();
        done = 4'b0;
        wait_grant(2, "wrap");
        done = 4'b0001;
        sb.push_back(2'd3);
        tick();
        done = 4'b0;
        wait_grant(2, "rerequest_other");
        req  = 4'b1000;
        done = 4'b1000;
        sb.push_back(2'd3);
        tick();
        done = 4'b0;
        wait_grant(2, "rerequest_alone");
        idle_out();
    endtask

    task automatic test_reset_mid_drive();
        req = 4'b0010;
        sb.push_back(2'd1);
        wait_grant(1, "mid_setup");
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (oe_n !== 4'hF || gnt !== 4'b0 || owner !== 2'd3 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: oe_n=%b gnt=%b owner=%0d busy=%b, required 1111 0000 3 0",
                     oe_n, gnt, owner, busy);
        end
        tick();
        n_checks++;
        if (oe_n !== 4'hF) begin
            n_errors++;
            $display("FAIL reset_hold: oe_n=%b, required 1111", oe_n);
        end
        rst = 1'b0;
        sb.push_back(2'd1);
        wait_grant(1, "after_reset");
        idle_out();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        req   = 4'b0;
        done  = 4'b0;
        req3  = 4'b0;
        done3 = 4'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_wrap();
        test_reset_mid_drive();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_sched.md
Name: bus_sched

Overview:
- Round-robin scheduler for the shared 4-bit logic-gate bus (NOR/NAND bus-variant chip models) and the CPU main bus.
- Grants exactly one requester at a time.
- Drives active-low output enables, in the same style as 74xx tristate chips.
- Inserts a turnaround gap between owners so two drivers never overlap.
- Sits between the control-word decoder and the tristate bus drivers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TURN_CYC, 1, idle cycles with all enables high between owners (1..7).
- MAX_HOLD, 0, maximum DRIVE cycles per grant; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester bus request, level.
- done  in  N_REQ  per-requester release pulse; only the current owner's bit is honoured.
- gnt  out  N_REQ  one-hot grant, registered.
- oe_n  out  N_REQ  active-low output enable to each driver, registered.
- owner  out  clog2(N_REQ)  index of the current/last owner.
- busy  out  1  high in DRIVE or TURN.
- timeout  out  1  one-cycle pulse when a MAX_HOLD expiry forces a release.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, gnt=0, oe_n=all 1, busy=0, timeout=0.
  - owner=N_REQ-1, so requester 0 has first priority.
  - hold counter=0, turn counter=0.
- IDLE:
  - If req!=0, the winner is the first set bit scanning from owner+1 upward, modulo N_REQ.
  - Next edge: state=DRIVE, gnt=onehot(winner), oe_n[winner]=0, owner=winner, busy=1.
  - Latency from req sampled high to oe_n low is 1 cycle.
- DRIVE:
  - Release condition: done[owner]=1, OR req[owner]=0, OR (MAX_HOLD!=0 and hold counter==MAX_HOLD-1).
  - On release, next edge: gnt=0, oe_n=all 1, state=TURN, turn counter=0.
  - timeout=1 for one cycle only when the release was caused by the MAX_HOLD expiry alone.
  - Hold counter increments each DRIVE cycle and is cleared on entering DRIVE.
  - done/req bits of non-owners are ignored in DRIVE.
- TURN:
  - oe_n stays all 1 and gnt=0.
  - After TURN_CYC cycles, state=IDLE and busy=0. Arbitration happens in IDLE, so the minimum gap between owners is TURN_CYC+1 cycles.
- Boundary and priority cases:
  - Simultaneous done and new requests from others: release always goes through TURN; never owner-to-owner directly.
  - Owner re-requests immediately after release: it is the lowest round-robin priority; it wins only if no other req bit is set.
  - Single requester holding req high with MAX_HOLD=4: DRIVE 4 cycles, TURN, IDLE, re-grant to the same requester.
  - Reset mid-DRIVE: oe_n goes all 1 asynchronously, with no glitch low.
  - Pointer wrap: owner=N_REQ-1 scans from index 0.
- Invariants (bench asserts every cycle):
  - At most one oe_n bit is low.
  - oe_n == ~gnt at all times.
- Out of range: req bits outside N_REQ do not exist. Unknown (X) inputs must not be masked — propagate X, matching gate-model test practice.

Decomposition:
- Package bus_sched_pkg:
  - State encoding: IDLE=2'd0, DRIVE=2'd1, TURN=2'd2.
  - Width helper function for clog2.
- Sub-module rr_pick (combinational):
  - Inputs: req and last pointer.
  - Outputs: winner index and any_req.
  - Instantiated once.
- Counters and the FSM live in bus_sched.

Test Plan:
- Reset, then req=4'b0001 at cycle 2 → gnt=0001, oe_n=1110 at cycle 3, owner=0, busy=1.
- Owner 0 pulses done → gnt=0000 and oe_n=1111 for TURN_CYC=1 cycle plus 1 IDLE cycle, then busy=0.
- req=4'b1111 held, done pulsed each grant → owners 0,1,2,3,0 in order, each grant separated by 2 cycles with all oe_n high.
- MAX_HOLD=3, req=4'b0100 held, no done → DRIVE exactly 3 cycles, timeout pulse on release, re-grant to owner 2 after the gap.
- owner=3 and req=4'b1001 after release → grant goes to 0 (wrap), not 3.
- Assert rst during DRIVE of owner 1 → oe_n=1111 the same cycle, gnt=0, owner=3; after deassert, req=4'b0010 → grant 1 after 1 cycle.
